instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter LAST_PC, default 508, the final fetch address; no sequential successor is issued after it.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  PC stage presents a fetch address.
REQ-005 SHALL have port in_pc  input  32  fetch address from the PC stage.
REQ-006 SHALL have port next_valid  output  1  one-cycle pulse returning the next address to the PC stage.
REQ-007 SHALL have port next_pc  output  32  next address for the PC stage.
REQ-008 SHALL have port imem_req  output  1  instruction memory read request.
REQ-009 SHALL have port imem_addr  output  32  instruction memory read address.
REQ-010 SHALL have port imem_ack  input  1  memory read complete; imem_rdata valid this cycle.
REQ-011 SHALL have port imem_rdata  input  32  instruction word.
REQ-012 SHALL have port redirect_valid  input  1  branch/jump redirect from a later stage.
REQ-013 SHALL have port redirect_pc  input  32  redirect target.
REQ-014 SHALL have port out_valid  output  1  fetched instruction available downstream.
REQ-015 SHALL have port out_ready  input  1  downstream accepts the instruction.
REQ-016 SHALL have port out_pc  output  32  address of the presented instruction.
REQ-017 SHALL have port out_instr  output  32  presented instruction word.
REQ-018 SHALL have port halted  output  1  LAST_PC instruction accepted; fetch stopped.

Function
REQ-019 SHALL implement states IDLE, WAIT, HOLD, DRAIN, HALT; all outputs registered.
REQ-020 IDLE: in_valid=1 at cycle t SHALL latch in_pc; imem_req=1, imem_addr=in_pc at t+1; go WAIT.
REQ-021 in_valid outside IDLE SHALL be ignored.
REQ-022 WAIT: imem_req and imem_addr SHALL stay stable until the imem_ack cycle; imem_req=0 the cycle after.
REQ-023 WAIT, imem_ack at cycle a: out_instr=imem_rdata, out_pc=latched pc, out_valid=1 at a+1; go HOLD.
REQ-024 HOLD: out_valid, out_pc, out_instr SHALL stay stable until out_ready=1.
REQ-025 HOLD, out_ready=1 at cycle h: out_valid=0 at h+1; if out_pc != LAST_PC, next_valid=1, next_pc=out_pc+4 (mod 2^32) at h+1, go IDLE; else next_valid stays 0, halted=1, go HALT.
REQ-026 next_valid SHALL be high exactly one cycle per issue.
REQ-027 Redirect in IDLE at cycle r SHALL give next_valid=1, next_pc=redirect_pc at r+1.
REQ-028 Redirect in HOLD SHALL drop out_valid at r+1 even with out_ready=1 at r, and issue next_pc=redirect_pc at r+1.
REQ-029 Redirect in WAIT without imem_ack SHALL store redirect_pc and go DRAIN; request stays until ack.
REQ-030 Redirect in WAIT with imem_ack the same cycle SHALL discard rdata and issue redirect_pc at r+1.
REQ-031 DRAIN: imem_ack SHALL discard rdata (no out_valid) and issue stored redirect_pc next cycle; a later redirect in DRAIN overwrites the stored target.
REQ-032 HALT: stays until rst; redirect ignored; all outputs 0 except halted=1.
REQ-033 Invalid state encoding SHALL recover to IDLE next cycle.

Reset
REQ-034 rst=1 SHALL force IDLE, next_valid=0, next_pc=0, imem_req=0, imem_addr=0, out_valid=0, out_pc=0, out_instr=0, halted=0, stored pc/target=0.
REQ-035 rst mid-transaction SHALL abandon the read; an imem_ack after rst release in IDLE SHALL be ignored.

Verification
REQ-036 in_pc=0x10 at t, ack at t+3 with rdata=0x00500093, out_ready=1 -> imem_req t+1..t+3, out_valid t+4, next_valid t+5 with next_pc=0x14.
REQ-037 out_ready held 0 for 5 cycles in HOLD -> out_pc/out_instr unchanged, no next_valid; ready=1 -> single next_valid pulse.
REQ-038 redirect_pc=0x80 in WAIT, ack 2 cycles later with rdata=0xDEADBEEF -> no out_valid, next_pc=0x80 one cycle after ack.
REQ-039 out_pc=508 accepted -> halted=1, no next_valid; later in_valid/redirect -> no imem_req.
REQ-040 rst asserted during WAIT, ack one cycle after release -> all outputs 0, no out_valid, state IDLE.
REQ-041 in_pc=0xFFFFFFFC (LAST_PC=0) accepted -> next_pc=0x00000000 wrap.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: takes a fetch address from the PC stage, performs one
// memory read, presents the instruction downstream and returns the successor PC.
module instr_fetch #(
    parameter logic [31:0] LAST_PC = 32'd508
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    output logic        next_valid,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        halted
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] target_reg, target_next;
    logic        next_valid_reg, next_valid_next;
    logic [31:0] next_pc_reg, next_pc_next;
    logic        imem_req_reg, imem_req_next;
    logic [31:0] imem_addr_reg, imem_addr_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] out_pc_reg, out_pc_next;
    logic [31:0] out_instr_reg, out_instr_next;
    logic        halted_reg, halted_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= 32'd0;
            target_reg     <= 32'd0;
            next_valid_reg <= 1'b0;
            next_pc_reg    <= 32'd0;
            imem_req_reg   <= 1'b0;
            imem_addr_reg  <= 32'd0;
            out_valid_reg  <= 1'b0;
            out_pc_reg     <= 32'd0;
            out_instr_reg  <= 32'd0;
            halted_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            target_reg     <= target_next;
            next_valid_reg <= next_valid_next;
            next_pc_reg    <= next_pc_next;
            imem_req_reg   <= imem_req_next;
            imem_addr_reg  <= imem_addr_next;
            out_valid_reg  <= out_valid_next;
            out_pc_reg     <= out_pc_next;
            out_instr_reg  <= out_instr_next;
            halted_reg     <= halted_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        target_next     = target_reg;
        next_valid_next = 1'b0;
        next_pc_next    = next_pc_reg;
        imem_req_next   = imem_req_reg;
        imem_addr_next  = imem_addr_reg;
        out_valid_next  = out_valid_reg;
        out_pc_next     = out_pc_reg;
        out_instr_next  = out_instr_reg;
        halted_next     = halted_reg;

        case (state_reg)
            ST_IDLE: begin
                // A redirect takes priority over a new fetch address.
                if (redirect_valid) begin
                    next_valid_next = 1'b1;
                    next_pc_next    = redirect_pc;
                end else if (in_valid) begin
                    pc_next        = in_pc;
                    imem_req_next  = 1'b1;
                    imem_addr_next = in_pc;
                    state_next     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    imem_req_next = 1'b0;
                    if (redirect_valid) begin
                        next_valid_next = 1'b1;
                        next_pc_next    = redirect_pc;
                        state_next      = ST_IDLE;
                    end else begin
                        out_valid_next = 1'b1;
                        out_pc_next    = pc_reg;
                        out_instr_next = imem_rdata;
                        state_next     = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    target_next = redirect_pc;
                    state_next  = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    out_valid_next  = 1'b0;
                    next_valid_next = 1'b1;
                    next_pc_next    = redirect_pc;
                    state_next      = ST_IDLE;
                end else if (out_ready) begin
                    out_valid_next = 1'b0;
                    if (out_pc_reg != LAST_PC) begin
                        next_valid_next = 1'b1;
                        next_pc_next    = out_pc_reg + 32'd4;
                        state_next      = ST_IDLE;
                    end else begin
                        next_pc_next   = 32'd0;
                        imem_addr_next = 32'd0;
                        out_pc_next    = 32'd0;
                        out_instr_next = 32'd0;
                        halted_next    = 1'b1;
                        state_next     = ST_HALT;
                    end
                end
            end
            ST_DRAIN: begin
                // The in-flight read must complete before the redirect is issued.
                if (imem_ack) begin
                    imem_req_next   = 1'b0;
                    next_valid_next = 1'b1;
                    next_pc_next    = redirect_valid ? redirect_pc : target_reg;
                    state_next      = ST_IDLE;
                end else if (redirect_valid) begin
                    target_next = redirect_pc;
                end
            end
            ST_HALT: begin
                next_pc_next   = 32'd0;
                imem_req_next  = 1'b0;
                imem_addr_next = 32'd0;
                out_valid_next = 1'b0;
                out_pc_next    = 32'd0;
                out_instr_next = 32'd0;
                halted_next    = 1'b1;
            end
            default: begin
                state_next     = ST_IDLE;
                pc_next        = 32'd0;
                target_next    = 32'd0;
                next_pc_next   = 32'd0;
                imem_req_next  = 1'b0;
                imem_addr_next = 32'd0;
                out_valid_next = 1'b0;
                out_pc_next    = 32'd0;
                out_instr_next = 32'd0;
                halted_next    = 1'b0;
            end
        endcase
    end

    assign next_valid = next_valid_reg;
    assign next_pc    = next_pc_reg;
    assign imem_req   = imem_req_reg;
    assign imem_addr  = imem_addr_reg;
    assign out_valid  = out_valid_reg;
    assign out_pc     = out_pc_reg;
    assign out_instr  = out_instr_reg;
    assign halted     = halted_reg;

endmodule
